// File: rtl/ttseq_pkg.sv
// Shared types and widths for the truth-table sequencer: FSM state encoding,
// vector/result/hold-counter widths and the saturating error-count helper.
package ttseq_pkg;

    localparam int VEC_W  = 3;
    localparam int RES_W  = 8;
    localparam int HOLD_W = 8;
    localparam int ERR_W  = 4;

    localparam logic [VEC_W-1:0] VEC_ONE  = 3'd1;
    localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;
    localparam logic [VEC_W-1:0] VEC_PARK = 3'b111;
    localparam logic [ERR_W-1:0] ERR_ONE  = 4'd1;
    localparam logic [ERR_W-1:0] ERR_MAX  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Only eight vectors exist, so the count can never exceed 8; clamp anyway.
    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] cnt);
        return (cnt >= ERR_MAX) ? ERR_MAX : cnt + ERR_ONE;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control/observe bundle between the sequencer and whoever drives it:
// sweep requests, the unit's F response, the A/B/C drives and the results.
interface truth_table_sequencer_if;
    import ttseq_pkg::*;

    logic             start;
    logic             abort;
    logic             f_in;
    logic             a_out;
    logic             b_out;
    logic             c_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [RES_W-1:0] fail_mask;
    logic [ERR_W-1:0] err_count;

    modport master (
        output start, abort, f_in,
        input  a_out, b_out, c_out, busy, done, pass, fail_mask, err_count
    );

    modport slave (
        input  start, abort, f_in,
        output a_out, b_out, c_out, busy, done, pass, fail_mask, err_count
    );

endinterface

// File: rtl/truth_table_sequencer_hold_counter.sv
// Per-vector hold counter: counts up while enabled, flags the last hold cycle.
module hold_counter
    import ttseq_pkg::*;
#(
    parameter int unsigned TC_VALUE = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [HOLD_W-1:0] TC_CNT  = HOLD_W'(TC_VALUE);
    localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_ONE;
        end
    end

    assign tc = (count == TC_CNT);

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives all eight {A,B,C} vectors into a combinational unit, holds each for
// HOLD_CYCLES, and checks F on the last hold cycle against the golden table.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no sweep; outputs zero; start begins a sweep
//   ST_APPLY | driving vec, counting hold cycles, compare on last cycle
//   ST_DONE  | results valid, a/b/c parked at 111; start restarts
module truth_table_sequencer
    import ttseq_pkg::*;
#(
    parameter int unsigned      HOLD_CYCLES = 10,
    parameter logic [RES_W-1:0] EXPECTED    = 8'b1100_1100
) (
    input  logic                    clk,
    input  logic                    rst,
    truth_table_sequencer_if.slave  bus
);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] abc;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [RES_W-1:0] fail_mask_r;
    logic [ERR_W-1:0] err_count_r;

    logic hold_tc;
    logic hold_clear;
    logic hold_en;
    logic mismatch;

    // Counter sits at zero outside APPLY, so a sweep always begins at count 0.
    assign hold_en    = (state == ST_APPLY);
    assign hold_clear = bus.abort || (state != ST_APPLY) || hold_tc;
    assign mismatch   = (bus.f_in != EXPECTED[vec]);

    hold_counter #(
        .TC_VALUE (HOLD_CYCLES - 1)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (hold_clear),
        .enable (hold_en),
        .tc     (hold_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            vec         <= '0;
            abc         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= '0;
            err_count_r <= '0;
        end else if (bus.abort) begin
            state       <= ST_IDLE;
            vec         <= '0;
            abc         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= '0;
            err_count_r <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state       <= ST_APPLY;
                        vec         <= '0;
                        abc         <= '0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        fail_mask_r <= '0;
                        err_count_r <= '0;
                    end
                end
                ST_APPLY: begin
                    if (hold_tc) begin
                        if (mismatch) begin
                            fail_mask_r[vec] <= 1'b1;
                            err_count_r      <= err_inc(err_count_r);
                        end
                        if (vec == VEC_LAST) begin
                            state  <= ST_DONE;
                            abc    <= VEC_PARK;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            // Last compare lands on this edge, so fold it in here.
                            pass_r <= !mismatch && (err_count_r == '0);
                        end else begin
                            vec <= vec + VEC_ONE;
                            abc <= vec + VEC_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_out     = abc[2];
    assign bus.b_out     = abc[1];
    assign bus.c_out     = abc[0];
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.fail_mask = fail_mask_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: default-parameter instance plus a
// HOLD_CYCLES=2 instance, each scenario in its own task.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic f_sel;
    logic f_force;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    truth_table_sequencer_if bus ();
    truth_table_sequencer_if bus2 ();

    // F = B reproduces the default golden table 8'b1100_1100.
    assign bus.f_in = f_sel ? f_force : bus.b_out;

    truth_table_sequencer #(.HOLD_CYCLES(10), .EXPECTED(8'b1100_1100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    truth_table_sequencer #(.HOLD_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // {busy, done, pass, a, b, c, fail_mask, err_count}
    function automatic logic [17:0] snap1();
        return {bus.busy, bus.done, bus.pass, bus.a_out, bus.b_out, bus.c_out,
                bus.fail_mask, bus.err_count};
    endfunction

    function automatic logic [17:0] snap2();
        return {bus2.busy, bus2.done, bus2.pass, bus2.a_out, bus2.b_out, bus2.c_out,
                bus2.fail_mask, bus2.err_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;  bus.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.f_in = 1'b0;
        f_sel = 1'b0; f_force = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL reset_dut1: got %h expected %h", snap1(), 18'd0);
        end
        n_checks++;
        if (snap2() !== 18'd0) begin
            n_fail++; $display("FAIL reset_dut2: got %h expected %h", snap2(), 18'd0);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h expected %h", snap1(), 18'd0);
        end
    endtask

    task automatic test_all_zero();
        int waited;
        f_sel = 1'b1; f_force = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.a_out, bus.b_out, bus.c_out} !== 4'b1000) begin
            n_fail++; $display("FAIL zero_first_cycle: got %b expected %b",
                               {bus.busy, bus.a_out, bus.b_out, bus.c_out}, 4'b1000);
        end
        waited = 0;
        while (!bus.done && waited < 200) begin tick(); waited++; end
        n_checks++;
        if (waited !== 80) begin
            n_fail++; $display("FAIL zero_done_latency: got %0d expected %0d", waited, 80);
        end
        n_checks++;
        if (snap1() !== {3'b010, 3'b111, 8'b1100_1100, 4'd4}) begin
            n_fail++; $display("FAIL zero_results: got %h expected %h", snap1(),
                               {3'b010, 3'b111, 8'b1100_1100, 4'd4});
        end
    endtask

    task automatic test_pass_sweep();
        logic [2:0] e_abc;
        f_sel = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_checks++;
        if (snap1() !== {3'b100, 3'b000, 8'h00, 4'd0}) begin
            n_fail++; $display("FAIL restart_clears: got %h expected %h", snap1(),
                               {3'b100, 3'b000, 8'h00, 4'd0});
        end
        for (int cyc = 1; cyc <= 80; cyc++) begin
            e_abc = 3'((cyc - 1) / 10);
            n_checks++;
            if ({bus.a_out, bus.b_out, bus.c_out} !== e_abc) begin
                n_fail++; $display("FAIL sweep_abc cyc %0d: got %b expected %b", cyc,
                                   {bus.a_out, bus.b_out, bus.c_out}, e_abc);
            end
            n_checks++;
            if ({bus.busy, bus.done, bus.pass} !== 3'b100) begin
                n_fail++; $display("FAIL sweep_flags cyc %0d: got %b expected %b", cyc,
                                   {bus.busy, bus.done, bus.pass}, 3'b100);
            end
            tick();
        end
        n_checks++;
        if (snap1() !== {3'b011, 3'b111, 8'h00, 4'd0}) begin
            n_fail++; $display("FAIL sweep_done_c81: got %h expected %h", snap1(),
                               {3'b011, 3'b111, 8'h00, 4'd0});
        end
    endtask

    task automatic test_abort();
        f_sel = 1'b1; f_force = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (34) tick();
        n_checks++;
        if (snap1() !== {3'b100, 3'd3, 8'h04, 4'd1}) begin
            n_fail++; $display("FAIL abort_pre_c35: got %h expected %h", snap1(),
                               {3'b100, 3'd3, 8'h04, 4'd1});
        end
        bus.abort = 1'b1; bus.start = 1'b1;
        tick();
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL abort_c36: got %h expected %h", snap1(), 18'd0);
        end
        tick();
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL abort_over_start: got %h expected %h", snap1(), 18'd0);
        end
        bus.abort = 1'b0; bus.start = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL abort_stays_idle: got %h expected %h", snap1(), 18'd0);
        end
    endtask

    task automatic test_async_reset();
        int waited;
        f_sel = 1'b1; f_force = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (54) tick();
        n_checks++;
        if (snap1() !== {3'b100, 3'd5, 8'h0C, 4'd2}) begin
            n_fail++; $display("FAIL vec5_partial: got %h expected %h", snap1(),
                               {3'b100, 3'd5, 8'h0C, 4'd2});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL async_reset_immediate: got %h expected %h", snap1(), 18'd0);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        repeat (3) tick();
        n_checks++;
        if (snap1() !== 18'd0) begin
            n_fail++; $display("FAIL needs_fresh_start: got %h expected %h", snap1(), 18'd0);
        end
        f_sel = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_checks++;
        if ({bus.busy, bus.a_out, bus.b_out, bus.c_out} !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset_vec0: got %b expected %b",
                               {bus.busy, bus.a_out, bus.b_out, bus.c_out}, 4'b1000);
        end
        waited = 0;
        while (!bus.done && waited < 200) begin tick(); waited++; end
        n_checks++;
        if (waited !== 80) begin
            n_fail++; $display("FAIL post_reset_latency: got %0d expected %0d", waited, 80);
        end
        n_checks++;
        if (snap1() !== {3'b011, 3'b111, 8'h00, 4'd0}) begin
            n_fail++; $display("FAIL post_reset_results: got %h expected %h", snap1(),
                               {3'b011, 3'b111, 8'h00, 4'd0});
        end
    endtask

    task automatic test_start_held();
        f_sel = 1'b1; f_force = 1'b0;
        bus.start = 1'b1;
        tick();
        repeat (80) tick();
        n_checks++;
        if (snap1() !== {3'b010, 3'b111, 8'hCC, 4'd4}) begin
            n_fail++; $display("FAIL held_done_a: got %h expected %h", snap1(),
                               {3'b010, 3'b111, 8'hCC, 4'd4});
        end
        tick();
        n_checks++;
        if (snap1() !== {3'b100, 3'b000, 8'h00, 4'd0}) begin
            n_fail++; $display("FAIL held_restart: got %h expected %h", snap1(),
                               {3'b100, 3'b000, 8'h00, 4'd0});
        end
        repeat (80) tick();
        n_checks++;
        if (snap1() !== {3'b010, 3'b111, 8'hCC, 4'd4}) begin
            n_fail++; $display("FAIL held_done_b: got %h expected %h", snap1(),
                               {3'b010, 3'b111, 8'hCC, 4'd4});
        end
        bus.start = 1'b0;
        tick();
        n_checks++;
        if (snap1() !== {3'b010, 3'b111, 8'hCC, 4'd4}) begin
            n_fail++; $display("FAIL done_holds: got %h expected %h", snap1(),
                               {3'b010, 3'b111, 8'hCC, 4'd4});
        end
    endtask

    task automatic test_short_hold();
        // Sampled F matches the golden table except vectors 0 and 5.
        logic [7:0] samp;
        int v;
        samp = 8'hED;
        bus2.start = 1'b1; tick(); bus2.start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            v = (cyc - 1) / 2;
            bus2.f_in = (cyc % 2 == 0) ? samp[v] : ~samp[v];
            n_checks++;
            if ({bus2.a_out, bus2.b_out, bus2.c_out} !== 3'(v)) begin
                n_fail++; $display("FAIL short_abc cyc %0d: got %b expected %b", cyc,
                                   {bus2.a_out, bus2.b_out, bus2.c_out}, 3'(v));
            end
            if (cyc == 16) begin
                n_checks++;
                if (bus2.done !== 1'b0) begin
                    n_fail++; $display("FAIL short_done_early: got %b expected %b", bus2.done, 1'b0);
                end
            end
            tick();
        end
        n_checks++;
        if (snap2() !== {3'b010, 3'b111, 8'h21, 4'd2}) begin
            n_fail++; $display("FAIL short_results_c17: got %h expected %h", snap2(),
                               {3'b010, 3'b111, 8'h21, 4'd2});
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_pass_sweep();
        test_abort();
        test_async_reset();
        test_start_held();
        test_short_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
